// File: rtl/mmio_pkg.sv
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared constants for the MMIO peripheral: register word
//                offsets inside the 0x800-0xFFF window and STATUS bit
//                positions, plus the window decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    // Register word indices (address[11:2])
    localparam logic [9:0] OFF_TXDATA  = 10'h200;
    localparam logic [9:0] OFF_STATUS  = 10'h201;
    localparam logic [9:0] OFF_CYCLE   = 10'h202;
    localparam logic [9:0] OFF_SCRATCH = 10'h203;
    localparam logic [9:0] OFF_HALT    = 10'h3FF;

    // STATUS register bit positions
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_HALT      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

    // The window is 0x800-0xFFF: upper address bits all zero and bit 11 set.
    function automatic logic in_window(input logic [31:0] addr);
        return (addr[31:12] == 20'h0) && addr[11];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_fifo.sv
// ============================================================================
//  Module      : mmio_fifo
//  Description : Byte-wide synchronous FIFO for the MMIO TX path. A push
//                arriving while full is still accepted when a pop happens
//                in the same cycle. The head reads as zero while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               AW           = $clog2(DEPTH);
    localparam logic [AW:0]      c_full_count = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic          w_pop;
    logic          w_push;

    // A pop on an empty FIFO is meaningless; a push at full only fits if
    // the head leaves in the same cycle.
    assign w_pop  = pop & (r_count != '0);
    assign w_push = push & ((r_count != c_full_count) | w_pop);

    assign empty = (r_count == '0);
    assign full  = (r_count == c_full_count);
    assign count = r_count;
    assign head  = empty ? 8'h00 : r_mem[r_rd_ptr];

    // Storage array: contents are don't-care while empty since head is gated.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a reset discards everything immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_periph.sv
// ============================================================================
//  Module      : mmio_periph
//  Description : Memory-mapped peripheral answering the 0x800-0xFFF window:
//                TX byte FIFO with valid/ready drain, STATUS, free-running
//                CYCLE counter, SCRATCH register and a sticky HALT flag.
//                Reads are combinational from registered state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_periph
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        we,
    output logic [31:0] data_out,
    output logic        hit,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [9:0]    w_word;
    logic          w_unused_addr;
    logic          w_wr;
    logic          w_sel_tx;
    logic          w_sel_status;
    logic          w_sel_scratch;
    logic          w_sel_halt;
    logic          w_push_req;
    logic          w_pop;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_empty;
    logic          w_full;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;

    logic          r_overflow;
    logic          r_halt;
    logic [31:0]   r_cycle;
    logic [31:0]   r_scratch;

    // Byte lane bits are not decoded; every register is word-wide.
    assign w_unused_addr = ^address[1:0];

    assign hit    = in_window(address);
    assign w_word = address[11:2];

    assign w_sel_tx      = (w_word == OFF_TXDATA);
    assign w_sel_status  = (w_word == OFF_STATUS);
    assign w_sel_scratch = (w_word == OFF_SCRATCH);
    assign w_sel_halt    = (w_word == OFF_HALT);

    // Once halted, data-path writes are frozen; HALT itself stays writable
    // (it is already set, so that is harmless).
    assign w_wr       = we & hit & ~r_halt;
    assign w_push_req = w_wr & w_sel_tx;
    assign w_pop      = tx_valid & tx_ready;
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = w_wr & w_sel_status & data_in[STAT_OVERFLOW];

    mmio_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_push_req),
        .push_data (data_in[7:0]),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );

    assign tx_valid = ~w_empty;
    assign tx_data  = w_head;
    assign halt     = r_halt;

    // Sticky overflow flag; a same-cycle set beats a software clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Halt latches on any write to its word and only reset clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_halt <= 1'b0;
        end else if (we && hit && w_sel_halt) begin
            r_halt <= 1'b1;
        end
    end

    // Free-running cycle counter, frozen while halted; wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cycle <= 32'h0;
        end else if (!r_halt) begin
            r_cycle <= r_cycle + 32'h1;
        end
    end

    // General-purpose scratch register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_scratch <= 32'h0;
        end else if (w_wr && w_sel_scratch) begin
            r_scratch <= data_in;
        end
    end

    // STATUS layout: count in [15:8], flags in [3:0].
    always_comb begin
        w_status = 32'h0;
        w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_count);
        w_status[STAT_OVERFLOW] = r_overflow;
        w_status[STAT_HALT]     = r_halt;
        w_status[STAT_FULL]     = w_full;
        w_status[STAT_EMPTY]    = w_empty;
    end

    // Combinational read mux; anything outside the window or unmapped reads 0.
    always_comb begin
        data_out = 32'h0;
        if (hit) begin
            case (w_word)
                OFF_STATUS:  data_out = w_status;
                OFF_CYCLE:   data_out = r_cycle;
                OFF_SCRATCH: data_out = r_scratch;
                OFF_HALT:    data_out = {31'h0, r_halt};
                default:     data_out = 32'h0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_periph.sv
// ============================================================================
//  Module      : tb_mmio_periph
//  Description : Self-checking bench for mmio_periph: table of register
//                accesses, directed FIFO/halt/reset sequences and random
//                traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_periph;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        we;
    logic [31:0] data_out;
    logic        hit;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;

    mmio_periph #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .address  (address),
        .data_in  (data_in),
        .we       (we),
        .data_out (data_out),
        .hit      (hit),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .halt     (halt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_q[$];
    bit          m_ovf;
    bit          m_halt;
    logic [31:0] m_cycle;
    logic [31:0] m_scratch;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_dout;
    logic [7:0]  last_txdata;
    logic        last_halt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_in_window(input logic [31:0] a);
        return (a < 32'h1000) && (a >= 32'h800);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] wa;
        int          n;
        wa = {a[31:2], 2'b00};
        n  = m_q.size();
        if (!m_in_window(a)) return 32'h0;
        if (wa == 32'h804)
            return (n * 256) + (m_ovf ? 8 : 0) + (m_halt ? 4 : 0)
                   + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0);
        if (wa == 32'h808) return m_cycle;
        if (wa == 32'h80C) return m_scratch;
        if (wa == 32'hFFC) return m_halt ? 32'h1 : 32'h0;
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf     = 1'b0;
        m_halt    = 1'b0;
        m_cycle   = 32'h0;
        m_scratch = 32'h0;
    endtask

    // Applies the effect of one rising edge using the inputs held during it.
    task automatic model_edge();
        logic [31:0] wa;
        bit          wr;
        bit          pop;
        bit          halt_next;
        wa        = {address[31:2], 2'b00};
        pop       = (m_q.size() > 0) && tx_ready;
        wr        = we && m_in_window(address) && !m_halt;
        halt_next = m_halt || (we && m_in_window(address) && wa == 32'hFFC);
        if (!m_halt) m_cycle = m_cycle + 32'h1;
        if (pop) void'(m_q.pop_front());
        if (wr && wa == 32'h804 && data_in[3]) m_ovf = 1'b0;
        if (wr && wa == 32'h800) begin
            if (m_q.size() < DEPTH) m_q.push_back(data_in[7:0]);
            else                    m_ovf = 1'b1;
        end
        if (wr && wa == 32'h80C) m_scratch = data_in;
        m_halt = halt_next;
    endtask

    // One clock: sample and compare at the falling edge, then step the model.
    task automatic cyc();
        logic [7:0] exp_tx;
        @(negedge clk);
        exp_tx      = (m_q.size() > 0) ? m_q[0] : 8'h00;
        last_dout   = data_out;
        last_txdata = tx_data;
        last_halt   = halt;
        chk("data_out", data_out, exp_read(address));
        chk("hit", {31'h0, hit}, {31'h0, m_in_window(address)});
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, (m_q.size() > 0)});
        chk("tx_data", {24'h0, tx_data}, {24'h0, exp_tx});
        chk("halt", {31'h0, halt}, {31'h0, m_halt});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        address  = a;
        data_in  = d;
        we       = 1'b1;
        tx_ready = rdy;
        cyc();
        we       = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic rdy);
        address  = a;
        we       = 1'b0;
        tx_ready = rdy;
        cyc();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [31:0] exp_dout;
        logic        exp_hit;
    } vec_t;

    vec_t tbl[$];

    logic [31:0] rand_addrs[9];

    initial begin
        resetn   = 1'b1;
        address  = 32'h0;
        data_in  = 32'h0;
        we       = 1'b0;
        tx_ready = 1'b0;
        #2;
        do_reset();

        // Counter starts at zero on release and counts every cycle.
        for (int i = 0; i < 3; i++) begin
            rd(32'h808, 1'b0);
            chk("cycle_after_reset", last_dout, i);
        end
        rd(32'h804, 1'b0);
        chk("status_reset", last_dout, 32'h1);
        chk("halt_reset", {31'h0, last_halt}, 32'h0);

        // Register access table: data_out is the value seen during that cycle.
        tbl.push_back('{32'h0000080C, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b1});
        tbl.push_back('{32'h0000080C, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1});
        tbl.push_back('{32'h0000080F, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1});
        tbl.push_back('{32'h00000000, 32'h0,        1'b0, 32'h00000000, 1'b0});
        tbl.push_back('{32'h0000000C, 32'h12345678, 1'b1, 32'h00000000, 1'b0});
        tbl.push_back('{32'h0000180C, 32'h12345678, 1'b1, 32'h00000000, 1'b0});
        tbl.push_back('{32'h0000080C, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1});
        tbl.push_back('{32'h00000810, 32'h55555555, 1'b1, 32'h00000000, 1'b1});
        tbl.push_back('{32'h00000810, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tbl.push_back('{32'h00000800, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tbl.push_back('{32'h00000FFC, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tbl.push_back('{32'h00000804, 32'hFFFFFFF7, 1'b1, 32'h00000001, 1'b1});
        tbl.push_back('{32'h00000804, 32'h0,        1'b0, 32'h00000001, 1'b1});
        foreach (tbl[i]) begin
            address  = tbl[i].addr;
            data_in  = tbl[i].wdata;
            we       = tbl[i].wen;
            tx_ready = 1'b0;
            cyc();
            we = 1'b0;
            chk($sformatf("tbl%0d_dout", i), last_dout, tbl[i].exp_dout);
            chk($sformatf("tbl%0d_hit", i), {31'h0, hit}, {31'h0, tbl[i].exp_hit});
        end

        // Fill to full with no drain, then overflow and clear it.
        for (int b = 8'h41; b <= 8'h48; b++) wr(32'h800, b, 1'b0);
        rd(32'h804, 1'b0);
        chk("status_full", last_dout, 32'h00000802);
        wr(32'h800, 32'h49, 1'b0);
        rd(32'h804, 1'b0);
        chk("status_overflow", last_dout, 32'h0000080A);
        wr(32'h804, 32'h8, 1'b0);
        rd(32'h804, 1'b0);
        chk("status_ovf_clear", last_dout, 32'h00000802);

        // Stall: head must hold until accepted.
        rd(32'h804, 1'b0); chk("stall0", {24'h0, last_txdata}, 32'h41);
        rd(32'h804, 1'b0); chk("stall1", {24'h0, last_txdata}, 32'h41);
        rd(32'h804, 1'b1); chk("stall2", {24'h0, last_txdata}, 32'h41);
        rd(32'h804, 1'b0); chk("stall_adv", {24'h0, last_txdata}, 32'h42);

        // Refill, then push at full with a simultaneous pop.
        wr(32'h800, 32'h4A, 1'b0);
        wr(32'h800, 32'h5A, 1'b1);
        chk("popped_head", {24'h0, last_txdata}, 32'h42);
        rd(32'h804, 1'b0);
        chk("push_pop_full", last_dout, 32'h00000802);
        chk("push_pop_head", {24'h0, last_txdata}, 32'h43);

        // Halt: counter freezes, scratch locked, FIFO still drains.
        wr(32'hFFC, 32'h0, 1'b0);
        rd(32'h808, 1'b0);
        chk("halt_set", {31'h0, last_halt}, 32'h1);
        wr(32'h80C, 32'h12345678, 1'b1);
        rd(32'h80C, 1'b1);
        chk("scratch_locked", last_dout, 32'hDEADBEEF);
        wr(32'h800, 32'h77, 1'b1);
        rd(32'h804, 1'b0);
        chk("halt_drain", last_dout, 32'h00000504);
        rd(32'hFFC, 1'b0);
        chk("halt_read", last_dout, 32'h1);

        // Asynchronous reset mid-cycle with bytes pending.
        #2;
        resetn = 1'b0;
        #1;
        chk("async_halt", {31'h0, halt}, 32'h0);
        chk("async_valid", {31'h0, tx_valid}, 32'h0);
        chk("async_txdata", {24'h0, tx_data}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Random traffic against the model, then halt and more traffic.
        rand_addrs = '{32'h800, 32'h800, 32'h801, 32'h804, 32'h808,
                       32'h80C, 32'h810, 32'h000, 32'h1800};
        for (int n = 0; n < 1800; n++) begin
            if (n == 1400) begin
                wr(32'hFFC, $urandom, 1'b0);
            end else begin
                address  = rand_addrs[$urandom_range(0, 8)];
                data_in  = $urandom;
                we       = ($urandom_range(0, 99) < 60);
                tx_ready = ($urandom_range(0, 99) < 40);
                cyc();
                we = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
